// File: rtl/jedro_1_defines.sv
// Shared definitions for the jedro_1 RV32I core: opcodes, ALU operations,
// opcode classes and the funct3-to-ALU mapping used by the decoder.
package jedro_1_defines;

  localparam int DATA_WIDTH = 32;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_FENCE = 7'b0001111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [2:0] {
    CLS_OP, CLS_OPIMM, CLS_LUI, CLS_AUIPC, CLS_FENCE
  } opc_class_e;

  // alt selects SUB/SRA over ADD/SRL; it is ignored for every other funct3.
  function automatic alu_op_e f3_to_alu(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ram_read_io.sv
// Read-only synchronous memory port: address out, data back one cycle later.
interface ram_read_io #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;

  modport MASTER (output addr, input data);
  modport SLAVE  (input addr, output data);
endinterface

// File: rtl/ram_rw_io.sv
// Single-port read/write memory port with enable and write-enable.
interface ram_rw_io #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  we;
  logic                  en;

  modport MASTER (output addr, output wdata, output we, output en, input rdata);
  modport SLAVE  (input addr, input wdata, input we, input en, output rdata);
endinterface

// File: rtl/jedro_1_alu.sv
// Combinational integer ALU; shift amounts come from the low five bits of op2.
module jedro_1_alu
  import jedro_1_defines::*;
(
  input  alu_op_e               op,
  input  logic [DATA_WIDTH-1:0] op1,
  input  logic [DATA_WIDTH-1:0] op2,
  output logic [DATA_WIDTH-1:0] res
);

  logic [4:0] shamt_s;
  assign shamt_s = op2[4:0];

  // Result select; SLT/SLTU produce 0/1 in the low bit.
  always_comb begin
    res = '0;
    case (op)
      ALU_ADD:  res = op1 + op2;
      ALU_SUB:  res = op1 - op2;
      ALU_SLL:  res = op1 << shamt_s;
      ALU_SLT:  res = {{(DATA_WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
      ALU_SLTU: res = {{(DATA_WIDTH-1){1'b0}}, (op1 < op2)};
      ALU_XOR:  res = op1 ^ op2;
      ALU_SRL:  res = op1 >> shamt_s;
      ALU_SRA:  res = $unsigned($signed(op1) >>> shamt_s);
      ALU_OR:   res = op1 | op2;
      ALU_AND:  res = op1 & op2;
      default:  res = '0;
    endcase
  end

endmodule

// File: rtl/jedro_1_decoder.sv
// Decode stage: checks legality of the fetched word and registers its fields.
// An illegal word raises a sticky flag that squashes everything decoded after it.
module jedro_1_decoder
  import jedro_1_defines::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [31:0]           instr,
  input  logic                  instr_valid,
  input  logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  valid_r,
  output opc_class_e            cls_r,
  output alu_op_e               alu_op_r,
  output logic [4:0]            rd_r,
  output logic [4:0]            rs1_r,
  output logic [4:0]            rs2_r,
  output logic [DATA_WIDTH-1:0] imm_r,
  output logic [ADDR_WIDTH-1:0] pc_r,
  output logic                  illegal_instr_ro
);

  logic [6:0] opcode_s;
  logic [2:0] f3_s;
  logic [6:0] f7_s;
  logic       legal_s;
  opc_class_e cls_s;
  alu_op_e    alu_s;
  logic [DATA_WIDTH-1:0] imm_s;

  assign opcode_s = instr[6:0];
  assign f3_s     = instr[14:12];
  assign f7_s     = instr[31:25];

  // Legality and class; funct7 is only free for immediate forms other than shifts.
  always_comb begin
    legal_s = 1'b0;
    cls_s   = CLS_FENCE;
    alu_s   = ALU_ADD;
    imm_s   = {{20{instr[31]}}, instr[31:20]};
    case (opcode_s)
      OPC_OP: begin
        cls_s = CLS_OP;
        alu_s = f3_to_alu(f3_s, f7_s[5]);
        if (f7_s == 7'b0000000) legal_s = 1'b1;
        else if ((f7_s == 7'b0100000) && ((f3_s == 3'b000) || (f3_s == 3'b101))) legal_s = 1'b1;
        else legal_s = 1'b0;
      end
      OPC_OPIMM: begin
        cls_s = CLS_OPIMM;
        alu_s = f3_to_alu(f3_s, (f3_s == 3'b101) && f7_s[5]);
        if (f3_s == 3'b001) legal_s = (f7_s == 7'b0000000);
        else if (f3_s == 3'b101) legal_s = (f7_s == 7'b0000000) || (f7_s == 7'b0100000);
        else legal_s = 1'b1;
      end
      OPC_LUI: begin
        cls_s   = CLS_LUI;
        imm_s   = {instr[31:12], 12'b0};
        legal_s = 1'b1;
      end
      OPC_AUIPC: begin
        cls_s   = CLS_AUIPC;
        imm_s   = {instr[31:12], 12'b0};
        legal_s = 1'b1;
      end
      OPC_FENCE: begin
        cls_s   = CLS_FENCE;
        legal_s = 1'b1;
      end
      default: legal_s = 1'b0;
    endcase
  end

  // Decode register; the halt flag only ever sets until reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_r          <= 1'b0;
      cls_r            <= CLS_FENCE;
      alu_op_r         <= ALU_ADD;
      rd_r             <= 5'd0;
      rs1_r            <= 5'd0;
      rs2_r            <= 5'd0;
      imm_r            <= '0;
      pc_r             <= '0;
      illegal_instr_ro <= 1'b0;
    end else begin
      valid_r  <= instr_valid && legal_s && !illegal_instr_ro;
      cls_r    <= cls_s;
      alu_op_r <= alu_s;
      rd_r     <= instr[11:7];
      rs1_r    <= instr[19:15];
      rs2_r    <= instr[24:20];
      imm_r    <= imm_s;
      pc_r     <= instr_pc;
      if (instr_valid && !legal_s) illegal_instr_ro <= 1'b1;
    end
  end

endmodule

// File: rtl/jedro_1_regfile.sv
// 32-entry integer register file: two asynchronous read ports, one write port, x0 hardwired to zero.
module jedro_1_regfile
  import jedro_1_defines::*;
(
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [4:0]            rs1_addr,
  input  logic [4:0]            rs2_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  input  logic                  we,
  input  logic [4:0]            rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] regfile [0:31];

  // Write port; index 0 is never written so it keeps its reset value.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < 32; i++) regfile[i] <= '0;
    end else if (we && (rd_addr != 5'd0)) begin
      regfile[rd_addr] <= rd_data;
    end
  end

  assign rs1_data = (rs1_addr == 5'd0) ? '0 : regfile[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? '0 : regfile[rs2_addr];

endmodule

// File: rtl/jedro_1_top.sv
// jedro_1 RV32I integer core: fetch, decode, execute/writeback in three stages.
// The data memory port is present but held idle.
module jedro_1_top #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  ram_read_io.MASTER instr_mem_if,
  ram_rw_io.MASTER   data_mem_if
);
  import jedro_1_defines::*;

  logic [ADDR_WIDTH-1:0] pc_r;
  logic [ADDR_WIDTH-1:0] fetch_pc_r;
  logic                  fetch_valid_r;

  logic                  dec_valid_s;
  opc_class_e            dec_cls_s;
  alu_op_e               dec_alu_op_s;
  logic [4:0]            dec_rd_s;
  logic [4:0]            dec_rs1_s;
  logic [4:0]            dec_rs2_s;
  logic [DATA_WIDTH-1:0] dec_imm_s;
  logic [ADDR_WIDTH-1:0] dec_pc_s;
  logic                  illegal_s;

  logic [DATA_WIDTH-1:0] rs1_data_s;
  logic [DATA_WIDTH-1:0] rs2_data_s;
  logic [DATA_WIDTH-1:0] op1_s;
  logic [DATA_WIDTH-1:0] op2_s;
  logic [DATA_WIDTH-1:0] alu_res_s;
  logic                  wb_en_s;
  logic                  unused_rdata_s;

  // Fetch: the ROM answers one cycle after the address, so the word's PC travels alongside.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pc_r          <= ADDR_WIDTH'(BOOT_ADDR);
      fetch_pc_r    <= ADDR_WIDTH'(BOOT_ADDR);
      fetch_valid_r <= 1'b0;
    end else if (!illegal_s) begin
      pc_r          <= pc_r + ADDR_WIDTH'(32'd4);
      fetch_pc_r    <= pc_r;
      fetch_valid_r <= 1'b1;
    end else begin
      fetch_valid_r <= 1'b0;
    end
  end

  assign instr_mem_if.addr = pc_r;

  jedro_1_decoder #(.ADDR_WIDTH(ADDR_WIDTH)) decoder_inst (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .instr            (instr_mem_if.data),
    .instr_valid      (fetch_valid_r),
    .instr_pc         (fetch_pc_r),
    .valid_r          (dec_valid_s),
    .cls_r            (dec_cls_s),
    .alu_op_r         (dec_alu_op_s),
    .rd_r             (dec_rd_s),
    .rs1_r            (dec_rs1_s),
    .rs2_r            (dec_rs2_s),
    .imm_r            (dec_imm_s),
    .pc_r             (dec_pc_s),
    .illegal_instr_ro (illegal_s)
  );

  jedro_1_regfile regfile_inst (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .rs1_addr (dec_rs1_s),
    .rs2_addr (dec_rs2_s),
    .rs1_data (rs1_data_s),
    .rs2_data (rs2_data_s),
    .we       (wb_en_s),
    .rd_addr  (dec_rd_s),
    .rd_data  (alu_res_s)
  );

  // Operand select: LUI adds its immediate to zero, AUIPC to the instruction's PC.
  always_comb begin
    op1_s = '0;
    op2_s = '0;
    case (dec_cls_s)
      CLS_OP:    begin op1_s = rs1_data_s;             op2_s = rs2_data_s; end
      CLS_OPIMM: begin op1_s = rs1_data_s;             op2_s = dec_imm_s;  end
      CLS_LUI:   begin op1_s = '0;                     op2_s = dec_imm_s;  end
      CLS_AUIPC: begin op1_s = DATA_WIDTH'(dec_pc_s);  op2_s = dec_imm_s;  end
      default:   begin op1_s = '0;                     op2_s = '0;         end
    endcase
  end

  jedro_1_alu alu_inst (
    .op  (dec_alu_op_s),
    .op1 (op1_s),
    .op2 (op2_s),
    .res (alu_res_s)
  );

  assign wb_en_s = dec_valid_s && (dec_cls_s != CLS_FENCE);

  assign data_mem_if.addr  = '0;
  assign data_mem_if.wdata = '0;
  assign data_mem_if.we    = 1'b0;
  assign data_mem_if.en    = 1'b0;
  assign unused_rdata_s    = ^data_mem_if.rdata;

endmodule

// File: tb/tb_jedro_1_top.sv
// Bench for jedro_1_top: directed and random programs run against an in-order
// ISA-level model; checks per-cycle writeback, halt timing, final state and resets.
module tb_jedro_1_top;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_AUI = 7'b0010111;
  localparam logic [6:0] OPC_FEN = 7'b0001111;

  logic clk_i;
  logic rstn_i;

  ram_read_io #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) imem ();
  ram_rw_io   #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dmem ();

  jedro_1_top #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BOOT_ADDR(32'h0000_0000)) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .instr_mem_if (imem),
    .data_mem_if  (dmem)
  );

  logic [31:0] rom    [0:255];
  logic [31:0] m_regs [0:31];
  bit          e_wr   [0:255];
  logic [4:0]  e_rd   [0:255];
  logic [31:0] e_val  [0:255];
  int          halt_idx;
  int          wp;
  int          chk_cnt;
  int          pass_cnt;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) imem.data <= rom[imem.addr[9:2]];
  assign dmem.rdata = 32'h0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OPC_R};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, OPC_I};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rd, opc};
  endfunction

  function automatic logic [31:0] alu_ref(input logic [2:0] f3, input bit alt,
                                          input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = b[4:0];
    case (f3)
      3'd0: if (alt) return a - b; else return a + b;
      3'd1: return a << sh;
      3'd2: if ($signed(a) < $signed(b)) return 32'd1; else return 32'd0;
      3'd3: if (a < b) return 32'd1; else return 32'd0;
      3'd4: return a ^ b;
      3'd5: if (alt) return $unsigned($signed(a) >>> sh); else return a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // Architectural effect of one instruction on m_regs.
  task automatic model_exec(input logic [31:0] ins, input logic [31:0] pc, output bit legal,
                            output bit wr, output logic [4:0] rd, output logic [31:0] val);
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a, b, immi;
    f3 = ins[14:12];
    f7 = ins[31:25];
    a = m_regs[ins[19:15]];
    b = m_regs[ins[24:20]];
    immi = {{20{ins[31]}}, ins[31:20]};
    rd = ins[11:7];
    legal = 1'b1;
    wr = 1'b1;
    val = 32'h0;
    case (ins[6:0])
      OPC_R:
        if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) val = alu_ref(f3, f7[5], a, b);
        else legal = 1'b0;
      OPC_I:
        if (f3 == 3'd1 && f7 != 7'h00) legal = 1'b0;
        else if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) legal = 1'b0;
        else val = alu_ref(f3, (f3 == 3'd5) && f7[5], a, immi);
      OPC_LUI: val = {ins[31:12], 12'h000};
      OPC_AUI: val = pc + {ins[31:12], 12'h000};
      OPC_FEN: wr = 1'b0;
      default: legal = 1'b0;
    endcase
    if (!legal || rd == 5'd0) wr = 1'b0;
    if (wr) m_regs[rd] = val;
  endtask

  task automatic run_model();
    bit legal, wr;
    logic [4:0] rd;
    logic [31:0] val;
    for (int r = 0; r < 32; r++) m_regs[r] = 32'h0;
    halt_idx = 256;
    for (int j = 0; j < 256 && halt_idx == 256; j++) begin
      model_exec(rom[j], 32'(4 * j), legal, wr, rd, val);
      e_wr[j] = wr;
      e_rd[j] = rd;
      e_val[j] = val;
      if (!legal) halt_idx = j;
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 32'h0000_0013;
    wp = 0;
  endtask

  task automatic put(input logic [31:0] w);
    rom[wp] = w;
    wp = wp + 1;
  endtask

  function automatic logic [31:0] rand_legal();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [6:0]  f7;
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    f3  = 3'($urandom_range(0, 7));
    imm = 12'($urandom);
    f7  = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    case ($urandom_range(0, 9))
      0, 1, 2, 3: return enc_r((f3 == 3'd0 || f3 == 3'd5) ? f7 : 7'h00, rs2, rs1, f3, rd);
      4, 5, 6: begin
        if (f3 == 3'd1) imm[11:5] = 7'h00;
        if (f3 == 3'd5) imm[11:5] = f7;
        return enc_i(imm, rs1, f3, rd);
      end
      7: return enc_u(20'($urandom), rd, OPC_LUI);
      8: return enc_u(20'($urandom), rd, OPC_AUI);
      default: return 32'h0ff0_000f;
    endcase
  endfunction

  function automatic logic [31:0] rand_illegal();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return enc_r(7'h01, 5'd1, 5'd2, 3'd0, 5'd3);
      3: return enc_r(7'h20, 5'd1, 5'd2, 3'd1, 5'd3);
      4: return enc_i({7'h20, 5'd3}, 5'd1, 3'd1, 5'd3);
      default: return {25'($urandom), 7'b0000011};
    endcase
  endfunction

  task automatic check_reset_state(input string tag);
    check_val({tag, "_pc"}, dut.pc_r, 32'h0);
    check_val({tag, "_ill"}, 32'(dut.decoder_inst.illegal_instr_ro), 32'h0);
    for (int r = 0; r < 32; r++)
      check_val($sformatf("%s_x%0d", tag, r), dut.regfile_inst.regfile[r], 32'h0);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk_i);
    rstn_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    check_reset_state({tag, "_rst"});
    rstn_i = 1'b1;
  endtask

  task automatic async_reset_check(input string tag);
    @(posedge clk_i);
    #3;
    rstn_i = 1'b0;
    #1;
    check_reset_state({tag, "_arst"});
  endtask

  // Edge k after release ends cycle k-1; word j is written back at edge j+3.
  task automatic run_prog(input string tag);
    int j;
    run_model();
    apply_reset(tag);
    for (int k = 1; k <= halt_idx + 8; k++) begin
      @(posedge clk_i);
      #1;
      j = k - 3;
      if (j >= 0 && j < halt_idx && e_wr[j])
        check_val($sformatf("%s_wb%0d_x%0d", tag, j, e_rd[j]), dut.regfile_inst.regfile[e_rd[j]], e_val[j]);
      if (k == halt_idx + 1)
        check_val({tag, "_ill_early"}, 32'(dut.decoder_inst.illegal_instr_ro), 32'h0);
      if (k == halt_idx + 2)
        check_val({tag, "_ill_set"}, 32'(dut.decoder_inst.illegal_instr_ro), 32'h1);
    end
    check_val({tag, "_pc_frozen"}, dut.pc_r, 32'(4 * halt_idx + 8));
    for (int r = 0; r < 32; r++)
      check_val($sformatf("%s_final_x%0d", tag, r), dut.regfile_inst.regfile[r], m_regs[r]);
  endtask

  initial begin
    rstn_i = 1'b0;
    chk_cnt = 0;
    pass_cnt = 0;

    clear_rom();
    put(enc_i(12'd8, 5'd0, 3'd0, 5'd1));
    put(enc_i(12'd3, 5'd0, 3'd0, 5'd2));
    put(enc_r(7'h00, 5'd2, 5'd1, 3'd5, 5'd31));
    put(32'h0000_0000);
    run_prog("srl");
    check_val("srl_x31", dut.regfile_inst.regfile[31], 32'h1);
    check_val("srl_halt", 32'(dut.decoder_inst.illegal_instr_ro), 32'h1);

    clear_rom();
    put(enc_i(12'd1, 5'd0, 3'd0, 5'd1));
    put(enc_i(12'd33, 5'd0, 3'd0, 5'd2));
    put(enc_r(7'h00, 5'd2, 5'd1, 3'd1, 5'd5));
    put(enc_i(12'hFF0, 5'd0, 3'd0, 5'd1));
    put(enc_i({7'h20, 5'd2}, 5'd1, 3'd5, 5'd3));
    put(enc_i({7'h00, 5'd28}, 5'd1, 3'd5, 5'd4));
    put(32'hFFFF_FFFF);
    run_prog("shift");
    check_val("sll_mask_x5", dut.regfile_inst.regfile[5], 32'h2);
    check_val("srai_x3", dut.regfile_inst.regfile[3], 32'hFFFF_FFFC);
    check_val("srli_x4", dut.regfile_inst.regfile[4], 32'h0000_000F);

    clear_rom();
    put(enc_i(12'd5, 5'd0, 3'd0, 5'd1));
    put(enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd1));
    put(enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd1));
    put(enc_u(20'h12345, 5'd6, OPC_LUI));
    put(enc_u(20'h00001, 5'd7, OPC_AUI));
    put(enc_i(12'd7, 5'd0, 3'd0, 5'd0));
    put(32'h0000_0000);
    put(enc_i(12'd1, 5'd0, 3'd0, 5'd8));
    run_prog("raw");
    check_val("raw_x1", dut.regfile_inst.regfile[1], 32'd20);
    check_val("lui_x6", dut.regfile_inst.regfile[6], 32'h1234_5000);
    check_val("auipc_x7", dut.regfile_inst.regfile[7], 32'h0000_1010);
    check_val("x0_zero", dut.regfile_inst.regfile[0], 32'h0);
    check_val("squash_x8", dut.regfile_inst.regfile[8], 32'h0);
    check_val("halt_pc", dut.pc_r, 32'h0000_0020);
    async_reset_check("halted");

    for (int t = 0; t < 8; t++) begin
      clear_rom();
      for (int i = 0, n = $urandom_range(8, 40); i < n; i++) put(rand_legal());
      put(rand_illegal());
      for (int i = 0; i < 6; i++) put(rand_legal());
      if (t % 2 == 1) begin
        apply_reset($sformatf("mid%0d", t));
        repeat ($urandom_range(5, 12)) @(posedge clk_i);
        async_reset_check($sformatf("mid%0d", t));
      end
      run_prog($sformatf("rnd%0d", t));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
